// File: rtl/serdesphy_pcs_pkg.sv
// Constants and aligner state encoding shared by the PCS receive aligner and transmit framer.
package serdesphy_pcs_pkg;

  localparam int SYMBOL_W       = 5;
  localparam logic [4:0] SYNC_SYM = 5'b11000;
  localparam int SYNC_LOCK_CNT  = 4;
  localparam int BAD_UNLOCK_CNT = 4;

  typedef enum logic [1:0] {
    ALIGN_HUNT   = 2'd0,
    ALIGN_VERIFY = 2'd1,
    ALIGN_LOCKED = 2'd2
  } align_state_e;

endpackage

// File: rtl/serdesphy_rx_symdec.sv
// Combinational classifier for one 5-bit line symbol: data, SYNC or invalid, plus the nibble.
module serdesphy_rx_symdec
  import serdesphy_pcs_pkg::*;
(
  input  logic [SYMBOL_W-1:0] sym,
  output logic                is_data,
  output logic                is_sync,
  output logic                is_invalid,
  output logic [3:0]          nibble
);

  always_comb begin
    is_data    = ~sym[SYMBOL_W-1];
    is_sync    = (sym == SYNC_SYM);
    is_invalid = sym[SYMBOL_W-1] & ~is_sync;
    nibble     = sym[3:0];
  end

endmodule

// File: rtl/serdesphy_rx_aligner.sv
// Serial RX symbol aligner: hunts for SYNC, verifies lock, decodes nibbles and tracks bad symbols.
// Define SERDESPHY_RX_ERR_CNT_EN to build the saturating rx_err_cnt counter.
module serdesphy_rx_aligner
  import serdesphy_pcs_pkg::*;
(
  input  logic       clk_240m_rx,
  input  logic       rst_n_240m_rx,
  input  logic       rx_en,
  input  logic       rx_align_rst,
  input  logic       rx_serial_data,
  input  logic       rx_serial_valid,
  input  logic       rx_serial_error,
  output logic [3:0] rx_data,
  output logic       rx_valid,
  output logic       rx_aligned,
  output logic       rx_idle,
  output logic       rx_code_err,
  output logic [7:0] rx_err_cnt
);

  localparam logic [2:0] SYNC_LAST = 3'(SYNC_LOCK_CNT - 1);
  localparam logic [1:0] BAD_LAST  = 2'(BAD_UNLOCK_CNT - 1);
  localparam logic [2:0] BIT_LAST  = 3'(SYMBOL_W - 1);

  align_state_e state_q, state_d;
  logic [4:0] win_q, win_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] sync_cnt_q, sync_cnt_d;
  logic [1:0] bad_cnt_q, bad_cnt_d;
  logic       sym_err_q, sym_err_d;
  logic [3:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       aligned_q, aligned_d;
  logic       idle_q, idle_d;
  logic       code_err_q, code_err_d;

  logic [4:0] win_shift;
  logic       is_data, is_sync, is_invalid;
  logic [3:0] nibble;
  logic       sym_done;
  logic       sym_bad;

  assign win_shift = {win_q[3:0], rx_serial_data};
  assign sym_done  = (bit_cnt_q == BIT_LAST);
  // A symbol is bad if its code is invalid or any of its five bits was flagged.
  assign sym_bad   = is_invalid | sym_err_q | rx_serial_error;

  serdesphy_rx_symdec u_symdec (
    .sym        (win_shift),
    .is_data    (is_data),
    .is_sync    (is_sync),
    .is_invalid (is_invalid),
    .nibble     (nibble)
  );

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    bit_cnt_d  = bit_cnt_q;
    sync_cnt_d = sync_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    sym_err_d  = sym_err_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    idle_d     = 1'b0;
    code_err_d = 1'b0;

    if (!rx_en || rx_align_rst) begin
      state_d    = ALIGN_HUNT;
      win_d      = '0;
      bit_cnt_d  = '0;
      sync_cnt_d = '0;
      bad_cnt_d  = '0;
      sym_err_d  = 1'b0;
    end else if (rx_serial_valid) begin
      win_d = win_shift;
      if (state_q == ALIGN_HUNT) begin
        if (win_shift == SYNC_SYM) begin
          state_d    = ALIGN_VERIFY;
          bit_cnt_d  = '0;
          sync_cnt_d = 3'd1;
          sym_err_d  = 1'b0;
        end
      end else if (!sym_done) begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        sym_err_d = sym_err_q | rx_serial_error;
      end else begin
        bit_cnt_d = '0;
        sym_err_d = 1'b0;
        if (state_q == ALIGN_VERIFY) begin
          if (is_sync) begin
            sync_cnt_d = sync_cnt_q + 3'd1;
            if (sync_cnt_q == SYNC_LAST) state_d = ALIGN_LOCKED;
          end else begin
            state_d    = ALIGN_HUNT;
            sync_cnt_d = '0;
          end
        end else if (sym_bad) begin
          code_err_d = 1'b1;
          if (bad_cnt_q == BAD_LAST) begin
            state_d   = ALIGN_HUNT;
            bad_cnt_d = '0;
          end else begin
            bad_cnt_d = bad_cnt_q + 2'd1;
          end
        end else begin
          bad_cnt_d = '0;
          if (is_sync) begin
            idle_d = 1'b1;
          end else if (is_data) begin
            valid_d = 1'b1;
            data_d  = nibble;
          end
        end
      end
    end

    aligned_d = (state_d == ALIGN_LOCKED);
  end

  always_ff @(posedge clk_240m_rx or negedge rst_n_240m_rx) begin
    if (!rst_n_240m_rx) begin
      state_q    <= ALIGN_HUNT;
      win_q      <= '0;
      bit_cnt_q  <= '0;
      sync_cnt_q <= '0;
      bad_cnt_q  <= '0;
      sym_err_q  <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      aligned_q  <= 1'b0;
      idle_q     <= 1'b0;
      code_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      bit_cnt_q  <= bit_cnt_d;
      sync_cnt_q <= sync_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      sym_err_q  <= sym_err_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      aligned_q  <= aligned_d;
      idle_q     <= idle_d;
      code_err_q <= code_err_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign rx_aligned  = aligned_q;
  assign rx_idle     = idle_q;
  assign rx_code_err = code_err_q;

`ifdef SERDESPHY_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Survives align resets and unlocks; only disabling the receiver clears it.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (!rx_en) begin
      err_cnt_d = '0;
    end else if (code_err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_240m_rx or negedge rst_n_240m_rx) begin
    if (!rst_n_240m_rx) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign rx_err_cnt = err_cnt_q;
`else
  assign rx_err_cnt = 8'h00;
`endif

endmodule
